// File: rtl/anvil_fetch_queue.sv
// anvil_fetch_queue: sequential instruction prefetcher with a DEPTH-entry
// {addr, word} FIFO between the instruction bus and decode.
// Optional feature macro: FETCH_BYPASS_EN (combinational empty-queue bypass
// from i_rdata/i_addr to inst/inst_addr).
//
// Handshakes: a bus transfer completes on a rising edge where i_valid && i_ready;
// i_valid/i_addr stay constant until then. The consumer takes the head on a
// rising edge where inst_valid && inst_ready. redirect_valid wins over both.
module anvil_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         resetn,
    output logic                         i_valid,
    input  logic                         i_ready,
    output logic [31:0]                  i_addr,
    input  logic [31:0]                  i_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_addr,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [1:0]                   fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;
    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_word [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, wr_en, rd_en, space_ok;

    // A response is kept only from a live (non-discarded) request without redirect.
    assign push     = (state_q == ST_REQ) && i_ready && !redirect_valid;
    assign rd_en    = (count_q != '0) && inst_ready && !redirect_valid;
    assign count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    assign space_ok = (count_d < DEPTH_C);

    assign i_valid    = (state_q != ST_IDLE);
    // While discarding, the abandoned address stays on the bus until it completes.
    assign i_addr     = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
    assign fill_level = count_q;
    assign fsm_state  = state_q;

    // Head presentation, optionally bypassing the storage when the queue is empty.
    always_comb begin
        wr_en      = push;
        inst_valid = (count_q != '0);
        inst       = mem_word[rd_ptr_q];
        inst_addr  = mem_addr[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
        if ((count_q == '0) && push) begin
            inst_valid = 1'b1;
            inst       = i_rdata;
            inst_addr  = i_addr;
            // A word consumed straight off the bus never occupies an entry.
            wr_en      = !inst_ready;
        end
`endif
    end

    // Request FSM next state and fetch address bookkeeping.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'd3;
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (i_ready) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d     = ST_DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end
                // A discard completing in the redirect cycle frees the bus at once.
                ST_DROP: state_d = i_ready ? ST_REQ : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: if (space_ok) state_d = ST_REQ;
                ST_REQ: begin
                    if (i_ready) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = space_ok ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DROP: if (i_ready) state_d = space_ok ? ST_REQ : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and fetch address registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // FIFO storage, pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_word[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_addr[wr_ptr_q] <= i_addr;
                mem_word[wr_ptr_q] <= i_rdata;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_anvil_fetch_queue.sv
// Bench for anvil_fetch_queue: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based model.
module tb_anvil_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       resetn;
    logic                       i_valid, i_ready;
    logic [31:0]                i_addr, i_rdata;
    logic                       inst_valid, inst_ready;
    logic [31:0]                inst, inst_addr;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic [$clog2(DEPTH+1)-1:0] fill_level;
    logic [1:0]                 fsm_state;

    int checks = 0;
    int errors = 0;

    anvil_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_addr(inst_addr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fill_level(fill_level), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_req: a bus request is outstanding; m_drop: its response will be thrown away;
    // m_bus_addr: address of that request; m_pc: next address to fetch.
    logic        m_req, m_drop;
    logic [31:0] m_pc, m_bus_addr;
    logic [63:0] exp_q[$];

    task automatic model_step();
        logic [31:0] tgt;
        bit          acc, was_empty, pop_ok;
        if (redirect_valid) begin
            tgt = {redirect_pc[31:2], 2'b00};
            exp_q.delete();
            if (m_req && !i_ready) begin
                m_drop = 1'b1;
            end else begin
                m_req      = 1'b1;
                m_drop     = 1'b0;
                m_bus_addr = tgt;
            end
            m_pc = tgt;
        end else begin
            acc       = m_req && i_ready;
            was_empty = (exp_q.size() == 0);
            pop_ok    = !was_empty && inst_ready;
            if (pop_ok) void'(exp_q.pop_front());
            if (acc && !m_drop) begin
                if (!(BYPASS_ON && was_empty && inst_ready))
                    exp_q.push_back({m_bus_addr, i_rdata});
                m_pc = m_bus_addr + 32'd4;
            end
            if (acc || !m_req) begin
                m_drop = 1'b0;
                if (exp_q.size() < DEPTH) begin
                    m_req      = 1'b1;
                    m_bus_addr = m_pc;
                end else begin
                    m_req = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_req      = 1'b0;
            m_drop     = 1'b0;
            m_pc       = RESET_PC;
            m_bus_addr = RESET_PC;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- scoreboard compare (every cycle, away from the edge) ----------------
    always @(negedge clk) begin
        logic [63:0] head;
        bit          byp;
        byp = BYPASS_ON && (exp_q.size() == 0) && m_req && !m_drop && i_ready
              && !redirect_valid && resetn;
        check("i_valid", 32'(i_valid), 32'(m_req));
        if (m_req) check("i_addr", i_addr, m_bus_addr);
        check("inst_valid", 32'(inst_valid), 32'((exp_q.size() != 0) || byp));
        check("fill_level", 32'(fill_level), 32'(exp_q.size()));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("inst", inst, head[31:0]);
            check("inst_addr", inst_addr, head[63:32]);
        end else if (byp) begin
            check("inst_byp", inst, i_rdata);
            check("inst_addr_byp", inst_addr, m_bus_addr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        i_rdata = $urandom();
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        resetn = 1'b0; i_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; i_rdata = '0;
        #2;
        check("rst_i_valid", 32'(i_valid), 32'd0);
        check("rst_i_addr", i_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        tick(); tick();

        // Streaming: bus and consumer always ready.
        resetn = 1'b1; i_ready = 1'b1; inst_ready = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            look();
            check("p1_i_addr", i_addr, 32'(k * 4));
            check("p1_fill_le1", 32'(fill_level <= 1), 32'd1);
            if (k > 0) check("p1_inst_addr", inst_addr, BYPASS_ON ? 32'(k * 4) : 32'((k - 1) * 4));
            tick();
        end

        // Reset while a request is on the bus.
        look(); #1;
        resetn = 1'b0;
        #1;
        check("rst_mid_i_valid", 32'(i_valid), 32'd0);
        check("rst_mid_fill", 32'(fill_level), 32'd0);
        tick();

        // Fill to full with the consumer stalled.
        i_ready = 1'b1; inst_ready = 1'b0; resetn = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            look();
            if (i_valid) n++;
            tick();
        end
        check("p2_push_count", 32'(n), 32'd4);
        look();
        check("p2_full_fill", 32'(fill_level), 32'd4);
        check("p2_full_idle", 32'(i_valid), 32'd0);
        check("p2_head_addr", inst_addr, 32'h0);
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            look();
            if (i_valid) begin
                n++;
                check("p2_refill_addr", i_addr, 32'h10);
            end
            tick();
        end
        check("p2_refill_count", 32'(n), 32'd1);
        check("p2_refill_fill", 32'(fill_level), 32'd4);

        // Redirect while waiting on 0x8 with the bus stalled.
        resetn = 1'b0; i_ready = 1'b1; inst_ready = 1'b1;
        tick();
        resetn = 1'b1;
        tick(); tick(); tick();
        check("p3_pre_addr", i_addr, 32'h8);
        i_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("p3_flush_fill", 32'(fill_level), 32'd0);
        check("p3_flush_valid", 32'(inst_valid), 32'd0);
        check("p3_hold0", i_addr, 32'h8);
        tick();
        check("p3_hold1", i_addr, 32'h8);
        tick();
        check("p3_hold2", i_addr, 32'h8);
        i_ready = 1'b1; i_rdata = 32'hDEAD_0008;
        tick();
        check("p3_target", i_addr, 32'h100);
        check("p3_dropped", 32'(fill_level), 32'd0);
        tick();
        check("p3_head_addr", inst_addr, 32'h100);
        check("p3_head_fill", 32'(fill_level), 32'd1);

        // Redirect together with a completing transfer and a pop.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; i_ready = 1'b0;
        #1;
        check("p4_fill", 32'(fill_level), 32'd0);
        check("p4_inst_valid", 32'(inst_valid), 32'd0);
        check("p4_target", i_addr, 32'h200);

        // Address wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; i_ready = 1'b1; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("p5_a0", i_addr, 32'hFFFF_FFF8);
        tick();
        check("p5_a1", i_addr, 32'hFFFF_FFFC);
        tick();
        check("p5_a2", i_addr, 32'h0000_0000);
        tick();
        check("p6_i_addr", i_addr, 32'h4);
`ifdef FETCH_BYPASS_EN
        check("p6_byp_valid", 32'(inst_valid), 32'd1);
        check("p6_byp_inst", inst, i_rdata);
        check("p6_byp_fill", 32'(fill_level), 32'd0);
`else
        check("p6_fill", 32'(fill_level), 32'd1);
        check("p6_head_addr", inst_addr, 32'h0);
`endif

        // Randomized traffic, with alternating consumer-stall epochs.
        for (int k = 0; k < 3000; k++) begin
            tick();
            i_ready        = ($urandom_range(0, 3) != 0);
            inst_ready     = ((k / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0)
                                                  : ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                         : $urandom();
        end
        tick();
        redirect_valid = 1'b0;
        look();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
